// File: rtl/summator_operand_ctrl_pkg.sv
// Shared definitions for the summator operand controller.
//   - state_e  : FSM state encoding (load a, load b, settle, result)
//   - DefaultWidth : default operand/result width, matches the 8-bit summator
//   - CntWidth : settle counter width (supports SETTLE_CYCLES up to 15)
package summator_operand_ctrl_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned CntWidth     = 4;

    typedef enum logic [1:0] {
        StLoadA  = 2'd0,
        StLoadB  = 2'd1,
        StSettle = 2'd2,
        StResult = 2'd3
    } state_e;

endpackage

// File: rtl/summator_operand_ctrl.sv
// Operand sequencer placed directly in front of a combinational summator.
// Pairs consecutive input bytes into operands a and b, holds them on the summator
// inputs for SETTLE_CYCLES clocks, captures the sum with carry and signed-overflow
// flags, and offers the result downstream over valid/ready. One pair in flight.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_data/valid/ready byte stream input; first byte of a pair is a, second is b
//   sum_a, sum_b        operands driven to the summator
//   sum_in              summator output
//   res_data/carry/ovf  captured sum and flags
//   res_valid/ready     result handshake
//   busy                high while settling or presenting a result
module summator_operand_ctrl
    import summator_operand_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = DefaultWidth,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum_a,
    output logic [WIDTH-1:0] sum_b,
    input  logic [WIDTH-1:0] sum_in,
    output logic [WIDTH-1:0] res_data,
    output logic             res_carry,
    output logic             res_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    // Counter reload value: capture happens SETTLE_CYCLES edges after b is taken.
    localparam logic [CntWidth-1:0] CntInit = CntWidth'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic [WIDTH-1:0]    sum_a_q, sum_a_d;
    logic [WIDTH-1:0]    sum_b_q, sum_b_d;
    logic [WIDTH-1:0]    res_data_q, res_data_d;
    logic                res_carry_q, res_carry_d;
    logic                res_ovf_q, res_ovf_d;
    logic                res_valid_q, res_valid_d;
    logic                in_xfer;

    // in_ready is registered, so a transfer is decided by the flopped value.
    assign in_xfer = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        sum_a_d     = sum_a_q;
        sum_b_d     = sum_b_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_ovf_d   = res_ovf_q;
        res_valid_d = res_valid_q;

        case (state_q)
            StLoadA: begin
                // Also covers the first edge after reset, where in_ready is still 0.
                in_ready_d = 1'b1;
                if (in_xfer) begin
                    sum_a_d = in_data;
                    state_d = StLoadB;
                end
            end
            StLoadB: begin
                in_ready_d = 1'b1;
                if (in_xfer) begin
                    sum_b_d    = in_data;
                    cnt_d      = CntInit;
                    in_ready_d = 1'b0;
                    state_d    = StSettle;
                end
            end
            StSettle: begin
                in_ready_d = 1'b0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    res_data_d  = sum_in;
                    // A modular sum smaller than an operand means it wrapped.
                    res_carry_d = (sum_in < sum_a_q);
                    res_ovf_d   = (sum_a_q[WIDTH-1] == sum_b_q[WIDTH-1]) &&
                                  (sum_in[WIDTH-1] != sum_a_q[WIDTH-1]);
                    res_valid_d = 1'b1;
                    state_d     = StResult;
                end
            end
            StResult: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StLoadA;
                end
            end
            default: begin
                state_d = StLoadA;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoadA;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            sum_a_q     <= '0;
            sum_b_q     <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_ovf_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            sum_a_q     <= sum_a_d;
            sum_b_q     <= sum_b_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_ovf_q   <= res_ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign sum_a     = sum_a_q;
    assign sum_b     = sum_b_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_ovf   = res_ovf_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q == StSettle) || (state_q == StResult);

endmodule

// File: tb/tb_summator_operand_ctrl.sv
// Bench for summator_operand_ctrl: instance 0 uses SETTLE_CYCLES=1, instance 1 uses
// SETTLE_CYCLES=3. Each instance is paired with a behavioural 8-bit summator.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_summator_operand_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data   [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] sum_a     [2];
    logic [7:0] sum_b     [2];
    logic [7:0] sum_in    [2];
    logic [7:0] res_data  [2];
    logic       res_carry [2];
    logic       res_ovf   [2];
    logic       res_valid [2];
    logic       res_ready [2];
    logic       busy      [2];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational summator: out = a + b mod 256.
    assign sum_in[0] = sum_a[0] + sum_b[0];
    assign sum_in[1] = sum_a[1] + sum_b[1];

    summator_operand_ctrl #(.WIDTH(8), .SETTLE_CYCLES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .sum_a     (sum_a[0]),
        .sum_b     (sum_b[0]),
        .sum_in    (sum_in[0]),
        .res_data  (res_data[0]),
        .res_carry (res_carry[0]),
        .res_ovf   (res_ovf[0]),
        .res_valid (res_valid[0]),
        .res_ready (res_ready[0]),
        .busy      (busy[0])
    );

    summator_operand_ctrl #(.WIDTH(8), .SETTLE_CYCLES(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .sum_a     (sum_a[1]),
        .sum_b     (sum_b[1]),
        .sum_in    (sum_in[1]),
        .res_data  (res_data[1]),
        .res_carry (res_carry[1]),
        .res_ovf   (res_ovf[1]),
        .res_valid (res_valid[1]),
        .res_ready (res_ready[1]),
        .busy      (busy[1])
    );

    // Reference: plain integer arithmetic, unsigned and signed views.
    function automatic void model(input int a, input int b, output logic [7:0] s,
                                  output logic c, output logic v);
        int u, sa, sb, t;
        u  = a + b;
        s  = 8'(u % 256);
        c  = (u > 255);
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        t  = sa + sb;
        v  = (t > 127) || (t < -128);
    endfunction

    // Offer one byte; returns at the falling edge after it was accepted.
    task automatic push(input int sel, input logic [7:0] d, output bit ok);
        ok = 0;
        in_data[sel]  = d;
        in_valid[sel] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready[sel]) begin
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        in_valid[sel] = 1'b0;
    endtask

    // Wait for res_valid, optionally stall for holdoff cycles, then handshake.
    task automatic get_result(input int sel, input int holdoff, output logic [7:0] d,
                              output logic c, output logic v, output int lat,
                              output bit ok);
        ok  = 0;
        lat = 0;
        d   = 8'h00;
        c   = 1'b0;
        v   = 1'b0;
        res_ready[sel] = (holdoff == 0);
        while (!res_valid[sel] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid[sel]) begin
            res_ready[sel] = 1'b0;
            return;
        end
        d = res_data[sel];
        c = res_carry[sel];
        v = res_ovf[sel];
        for (int i = 0; i < holdoff; i++) begin
            @(negedge clk);
            total++;
            if (res_valid[sel] !== 1'b1 || res_data[sel] !== d || in_ready[sel] !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold sel=%0d: valid=%b data=%h in_ready=%b, need 1/%h/0",
                         sel, res_valid[sel], res_data[sel], in_ready[sel], d);
            end
        end
        res_ready[sel] = 1'b1;
        @(negedge clk);
        res_ready[sel] = 1'b0;
        ok = 1;
    endtask

    task automatic run_pair(input int sel, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] es, input logic ec, input logic ev,
                            input int gap, input int holdoff, input bit early);
        bit ok;
        logic [7:0] d;
        logic c, v;
        int lat;
        int exp_lat;
        exp_lat = (sel == 0) ? 1 : 3;
        if (early) res_ready[sel] = 1'b1;
        push(sel, a, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL push_a sel=%0d: byte %h not accepted, need accepted", sel, a);
        end
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            total++;
            if (in_ready[sel] !== 1'b1 || sum_a[sel] !== a || busy[sel] !== 1'b0) begin
                bad++;
                $display("FAIL gap_hold sel=%0d: in_ready=%b sum_a=%h busy=%b, need 1/%h/0",
                         sel, in_ready[sel], sum_a[sel], busy[sel], a);
            end
        end
        push(sel, b, ok);
        total++;
        if (!ok || busy[sel] !== 1'b1 || in_ready[sel] !== 1'b0) begin
            bad++;
            $display("FAIL push_b sel=%0d: ok=%0d busy=%b in_ready=%b, need 1/1/0",
                     sel, ok, busy[sel], in_ready[sel]);
        end
        get_result(sel, holdoff, d, c, v, lat, ok);
        total++;
        if (!ok || lat != exp_lat) begin
            bad++;
            $display("FAIL latency sel=%0d: ok=%0d edges=%0d, need %0d", sel, ok, lat, exp_lat);
        end
        total++;
        if (d !== es || c !== ec || v !== ev) begin
            bad++;
            $display("FAIL result sel=%0d %h+%h: got %h c=%b v=%b, need %h c=%b v=%b",
                     sel, a, b, d, c, v, es, ec, ev);
        end
        total++;
        if (res_valid[sel] !== 1'b0 || in_ready[sel] !== 1'b1 || sum_a[sel] !== a ||
            sum_b[sel] !== b) begin
            bad++;
            $display("FAIL after_hs sel=%0d: valid=%b in_ready=%b a=%h b=%h, need 0/1/%h/%h",
                     sel, res_valid[sel], in_ready[sel], sum_a[sel], sum_b[sel], a, b);
        end
    endtask

    task automatic test_reset;
        bit ok;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_data[s] = 8'h00; in_valid[s] = 1'b0; res_ready[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            total++;
            if (in_ready[s] !== 1'b0 || sum_a[s] !== 8'h00 || sum_b[s] !== 8'h00 ||
                res_data[s] !== 8'h00 || res_carry[s] !== 1'b0 || res_ovf[s] !== 1'b0 ||
                res_valid[s] !== 1'b0 || busy[s] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state sel=%0d: rdy=%b a=%h b=%h d=%h c=%b v=%b vld=%b bsy=%b",
                         s, in_ready[s], sum_a[s], sum_b[s], res_data[s], res_carry[s],
                         res_ovf[s], res_valid[s], busy[s]);
            end
        end
        // 0x11 held across release: first edge only raises in_ready.
        in_data[0] = 8'h11;
        in_valid[0] = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready[0] !== 1'b1 || sum_a[0] !== 8'h00) begin
            bad++;
            $display("FAIL release_edge1: in_ready=%b sum_a=%h, need 1/00", in_ready[0], sum_a[0]);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        total++;
        if (sum_a[0] !== 8'h11 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL release_edge2: sum_a=%h in_ready=%b busy=%b, need 11/1/0",
                     sum_a[0], in_ready[0], busy[0]);
        end
        push(0, 8'h22, ok);
        begin
            logic [7:0] d;
            logic c, v;
            int lat;
            get_result(0, 0, d, c, v, lat, ok);
            total++;
            if (!ok || d !== 8'h33 || c !== 1'b0 || v !== 1'b0) begin
                bad++;
                $display("FAIL release_pair: got %h c=%b v=%b, need 33 c=0 v=0", d, c, v);
            end
        end
    endtask

    task automatic test_directed;
        run_pair(0, 8'h55, 8'h01, 8'h56, 1'b0, 1'b0, 0, 0, 1);
        run_pair(0, 8'h55, 8'h05, 8'h5A, 1'b0, 1'b0, 0, 0, 1);
        run_pair(0, 8'h99, 8'h05, 8'h9E, 1'b0, 1'b0, 0, 0, 0);
        run_pair(0, 8'h80, 8'h10, 8'h90, 1'b0, 1'b0, 0, 0, 0);
        run_pair(0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0, 0, 0);
        run_pair(0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0, 0, 0);
        run_pair(0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 0, 0, 0);
    endtask

    task automatic test_backpressure;
        bit ok;
        push(0, 8'h55, ok);
        push(0, 8'h01, ok);
        in_data[0]   = 8'h22;
        in_valid[0]  = 1'b1;
        res_ready[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (res_valid[0] !== 1'b1 || res_data[0] !== 8'h56 || in_ready[0] !== 1'b0 ||
                sum_a[0] !== 8'h55) begin
                bad++;
                $display("FAIL backpressure cyc=%0d: vld=%b data=%h rdy=%b a=%h, need 1/56/0/55",
                         i, res_valid[0], res_data[0], in_ready[0], sum_a[0]);
            end
            @(negedge clk);
        end
        res_ready[0] = 1'b1;
        @(negedge clk);
        res_ready[0] = 1'b0;
        total++;
        if (res_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || sum_a[0] !== 8'h55) begin
            bad++;
            $display("FAIL bp_release: vld=%b rdy=%b a=%h, need 0/1/55",
                     res_valid[0], in_ready[0], sum_a[0]);
        end
        @(negedge clk);
        total++;
        if (sum_a[0] !== 8'h22) begin
            bad++;
            $display("FAIL bp_next_a: sum_a=%h, need 22", sum_a[0]);
        end
        push(0, 8'h10, ok);
        begin
            logic [7:0] d;
            logic c, v;
            int lat;
            get_result(0, 0, d, c, v, lat, ok);
            total++;
            if (!ok || d !== 8'h32) begin
                bad++;
                $display("FAIL bp_pair: got %h, need 32", d);
            end
        end
    endtask

    task automatic test_gaps;
        run_pair(0, 8'h3C, 8'h44, 8'h80, 1'b0, 1'b1, 5, 0, 0);
        run_pair(1, 8'h55, 8'h01, 8'h56, 1'b0, 1'b0, 0, 0, 0);
        run_pair(1, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 2, 3, 1);
    endtask

    task automatic test_mid_reset;
        bit ok;
        push(0, 8'h55, ok);
        push(0, 8'h01, ok);
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready[0] !== 1'b0 || sum_a[0] !== 8'h00 || sum_b[0] !== 8'h00 ||
            res_data[0] !== 8'h00 || res_valid[0] !== 1'b0 || busy[0] !== 1'b0 ||
            res_carry[0] !== 1'b0 || res_ovf[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: rdy=%b a=%h b=%h d=%h vld=%b bsy=%b, need all 0",
                     in_ready[0], sum_a[0], sum_b[0], res_data[0], res_valid[0], busy[0]);
        end
        repeat (2) @(negedge clk);
        total++;
        if (res_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_hold: res_valid=%b, need 0", res_valid[0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready[0] !== 1'b1 || res_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_release: rdy=%b vld=%b, need 1/0", in_ready[0], res_valid[0]);
        end
        run_pair(0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b, s;
            logic c, v;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            model(int'(a), int'(b), s, c, v);
            run_pair(i % 2, a, b, s, c, v, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_gaps();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
